alu_issue_stage: RTL and testbench

- Buffered issue stage directly upstream of the `alu`. It accepts {aluop, a, b} operations over a valid/ready handshake and queues them in a small FIFO.
- It drives the FIFO head into an internally instantiated `alu` (r1_data=a, r2_data=b, fn=aluop) and captures y/zero into a registered output slot with its own valid/ready handshake.
- It sits between decode/test-vector sources and writeback consumers. It gives the combinational ALU registered, back-pressurable boundaries.

---
 rtl/alu_issue_stage.sv | 203 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffered issue stage in front of the combinational ALU.
//
// Operations {aluop, a, b} are accepted over a valid/ready handshake into a
// DEPTH-entry FIFO. The FIFO head feeds the ALU directly, and the result is
// captured into a registered output slot that has its own valid/ready
// handshake. Both ends are therefore registered and can be back-pressured.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready depends only on count)
//   in_aluop/in_a/in_b  operation: ALU function code and operands
//   out_valid/out_ready downstream handshake for the result slot
//   out_result/out_zero registered alu.y / alu.zero
//   out_aluop           function code that produced out_result
//   busy                FIFO non-empty or result slot occupied
//   op_cnt/zero_cnt     issue count / zero-result issue count
//                       (present only when ALU_ISSUE_STAT_EN is defined)
//
// Optional feature macro: ALU_ISSUE_STAT_EN

// Combinational ALU: y = fn(r1_data, r2_data), zero = (y == 0).
// Unused function codes produce 0.
module alu (
   input  logic [3:0]  fn,
   input  logic [31:0] r1_data,
   input  logic [31:0] r2_data,
   output logic [31:0] y,
   output logic        zero
);
   always_comb begin
      y = '0;
      case (fn)
         4'b0000: y = r1_data & r2_data;
         4'b0001: y = r1_data | r2_data;
         4'b0010: y = r1_data + r2_data;
         4'b0110: y = r1_data - r2_data;
         4'b0111: y = {31'b0, $signed(r1_data) < $signed(r2_data)};
         4'b1100: y = ~(r1_data | r2_data);
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);
endmodule

module alu_issue_stage #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_aluop,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic [3:0]  out_aluop,
   output logic        busy
`ifdef ALU_ISSUE_STAT_EN
   ,
   output logic [15:0] op_cnt,
   output logic [15:0] zero_cnt
`endif
);
   typedef struct packed {
      logic [3:0]  aluop;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   op_t         mem_q [DEPTH];
   op_t         mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_result_q, out_result_d;
   logic          out_zero_q, out_zero_d;
   logic [3:0]    out_aluop_q, out_aluop_d;

   op_t         head;
   logic [31:0] alu_y;
   logic        alu_zero;
   logic        push, issue, slot_free;

   assign head = mem_q[rd_ptr_q];

   alu u_alu (
      .fn      (head.aluop),
      .r1_data (head.a),
      .r2_data (head.b),
      .y       (alu_y),
      .zero    (alu_zero)
   );

   // in_ready looks only at the registered count, so a full FIFO stays
   // closed for the edge on which it issues; no out_ready -> in_ready path.
   assign in_ready  = (count_q < DEPTH_C);
   assign push      = in_valid && in_ready;
   assign slot_free = !out_valid_q || out_ready;
   // Issue uses the registered count, so an op pushed into an empty FIFO
   // cannot issue on the same edge (no bypass).
   assign issue     = (count_q != '0) && slot_free;

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_zero_d   = out_zero_q;
      out_aluop_d  = out_aluop_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{aluop: in_aluop, a: in_a, b: in_b};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      if (issue) begin
         out_result_d = alu_y;
         out_zero_d   = alu_zero;
         out_aluop_d  = head.aluop;
         out_valid_d  = 1'b1;
         rd_ptr_d     = rd_ptr_q + PTR_ONE;
      end else if (out_valid_q && out_ready) begin
         // Slot was free but nothing queued: drain, keep data registers.
         out_valid_d = 1'b0;
      end

      case ({push, issue})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage carries no reset; its contents are only read when count!=0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         out_aluop_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_zero_q   <= out_zero_d;
         out_aluop_q  <= out_aluop_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_aluop  = out_aluop_q;
   assign busy       = (count_q != '0) || out_valid_q;

`ifdef ALU_ISSUE_STAT_EN
   logic [15:0] op_cnt_q, op_cnt_d;
   logic [15:0] zero_cnt_q, zero_cnt_d;

   always_comb begin
      op_cnt_d   = op_cnt_q;
      zero_cnt_d = zero_cnt_q;
      if (issue) begin
         op_cnt_d = op_cnt_q + 16'd1;
         if (alu_zero) zero_cnt_d = zero_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_q   <= '0;
         zero_cnt_q <= '0;
      end else begin
         op_cnt_q   <= op_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign op_cnt   = op_cnt_q;
   assign zero_cnt = zero_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
   localparam int DEPTH = 2;
   localparam int AW    = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_aluop = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_zero;
   logic [3:0]  out_aluop;
   logic        busy;
`ifdef ALU_ISSUE_STAT_EN
   logic [15:0] op_cnt;
   logic [15:0] zero_cnt;
`endif

   alu_issue_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_aluop   (in_aluop),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_aluop  (out_aluop),
      .busy       (busy)
`ifdef ALU_ISSUE_STAT_EN
      ,
      .op_cnt     (op_cnt),
      .zero_cnt   (zero_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: queue of pending ops plus one result slot.
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   op_t         q[$];
   bit          m_v;
   logic [31:0] m_y;
   logic        m_z;
   logic [3:0]  m_op;
   logic [15:0] m_opc, m_zc;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] alu_ref(logic [3:0] fn, logic [31:0] a, logic [31:0] b);
      case (fn)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_v = 0; m_y = '0; m_z = 0; m_op = '0; m_opc = '0; m_zc = '0;
   endtask

   task automatic compare_model();
      chk("in_ready", in_ready, (q.size() < DEPTH));
      chk("out_valid", out_valid, m_v);
      chk("busy", busy, (q.size() != 0) || m_v);
      chk("out_result", out_result, m_y);
      chk("out_zero", out_zero, m_z);
      chk("out_aluop", out_aluop, m_op);
`ifdef ALU_ISSUE_STAT_EN
      chk("op_cnt", op_cnt, m_opc);
      chk("zero_cnt", zero_cnt, m_zc);
`endif
   endtask

   // One clock: drive at negedge, advance model at posedge, compare #1 later.
   task automatic step(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b, bit rdy);
      op_t e;
      bit push, issue;
      @(negedge clk);
      in_valid = v; in_aluop = op; in_a = a; in_b = b; out_ready = rdy;
      @(posedge clk);
      push  = v && (q.size() < DEPTH);
      issue = (q.size() != 0) && (!m_v || rdy);
      if (issue) begin
         e    = q.pop_front();
         m_y  = alu_ref(e.op, e.a, e.b);
         m_z  = (m_y == 32'd0);
         m_op = e.op;
         m_v  = 1;
         m_opc++;
         if (m_z) m_zc++;
      end else if (m_v && rdy) begin
         m_v = 0;
      end
      if (push) begin
         e.op = op; e.a = a; e.b = b;
         q.push_back(e);
      end
      #1 compare_model();
   endtask

   task automatic apply_reset();
      in_valid = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rst_hold_out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      model_reset();
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   function automatic logic [3:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 4'b0000;
         1: return 4'b0001;
         2: return 4'b0010;
         3: return 4'b0110;
         4: return 4'b0111;
         5: return 4'b1100;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int streak;
      logic [31:0] ra, rb;
      model_reset();
      apply_reset();

      // Single add: result appears one edge after acceptance.
      step(1, 4'b0010, 32'h5, 32'h3, 1);
      chk("add_not_yet_valid", out_valid, 0);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 32'h8);
      chk("add_zero", out_zero, 0);
      chk("add_aluop", out_aluop, 4'b0010);

      // Zero flag from a fresh reset.
      apply_reset();
      step(1, 4'b0110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("sub_result", out_result, 32'h0);
      chk("sub_zero", out_zero, 1);
`ifdef ALU_ISSUE_STAT_EN
      chk("sub_op_cnt", op_cnt, 16'd1);
      chk("sub_zero_cnt", zero_cnt, 16'd1);
`endif
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("drain_valid", out_valid, 0);

      // Back-pressure: three pushes with out_ready low.
      step(1, 4'b0010, 32'd1, 32'd1, 0);
      step(1, 4'b0010, 32'd10, 32'd20, 0);
      step(1, 4'b0001, 32'hF0, 32'h0F, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_op1", out_result, 32'd2);
      step(0, 4'b0000, 32'h0, 32'h0, 0);
      chk("bp_stall_op1", out_result, 32'd2);
      chk("bp_stall_valid", out_valid, 1);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("bp_op2", out_result, 32'd30);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("bp_op3", out_result, 32'hFF);
      chk("bp_op3_aluop", out_aluop, 4'b0001);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("bp_drained", out_valid, 0);

      // Streaming: 10 back-to-back ops give 10 consecutive valid cycles.
      streak = 0;
      for (int i = 0; i < 11; i++) begin
         ra = $urandom;
         rb = $urandom;
         step(i < 10, rand_op(), ra, rb, 1);
         if (out_valid) streak++;
      end
      chk("stream_valid_cycles", streak, 10);
      step(0, 4'b0000, 32'h0, 32'h0, 1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         step($urandom_range(0, 3) != 0, rand_op(), ra, rb, $urandom_range(0, 2) != 0);
      end

      // Mid-operation reset with the FIFO full and the slot held.
      for (int i = 0; i < 4; i++) step(1, 4'b0010, 32'd7, 32'd9, 0);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_in_ready", in_ready, 1);
      chk("async_out_result", out_result, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("post_rst_no_stale", out_valid, 0);
      step(1, 4'b1100, 32'h0, 32'h0, 1);
      step(0, 4'b0000, 32'h0, 32'h0, 1);
      chk("post_rst_nor", out_result, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
